calc_control: RTL and testbench
===============================

// Module: calc_control
// PURPOSE
//   Control sequencer directly upstream of registerX/registerY/registerZ and the ALU.
//   Accepts one operation request, then drives the per-register op codes (Tx, Ty, Tz)
//   and the ALU select over a fixed multi-cycle sequence. It signals completion with done.
//   Updates on posedge clk, so codes are stable when the registers sample on negedge clk.
// PARAMETERS
//   CODE_W   4   width of Tx/Ty/Tz buses; codes HOLD=0 LOAD=1 SHIFTR=2 SHIFTL=3 CLEAR=4
//   AMT_W    2   width of shift-repeat field amt
// PORTS
//   clk      in   1        system clock, posedge active
//   rst      in   1        synchronous reset, active-high
//   start    in   1        request strobe; sampled only in IDLE
//   op       in   3        0 ADD,1 SUB,2 AND,3 OR,4 SHR,5 SHL,6 CLR,7 reserved
//   amt      in   AMT_W    shift repeat: SHR/SHL executed amt+1 times
//   Tx       out  CODE_W   op code to registerX
//   Ty       out  CODE_W   op code to registerY (Y loads ALU result)
//   Tz       out  CODE_W   op code to registerZ (Z loads outY)
//   alu_sel  out  2        ALU function select (= op[1:0] during EXEC)
//   busy     out  1        high in every state except IDLE
//   done     out  1        one-cycle pulse when sequence ends
//   err      out  1        high with done for reserved op; else 0
// BEHAVIOUR
//   Reset (rst=1 at posedge): state=IDLE; Tx=Ty=Tz=HOLD; alu_sel=0; busy=done=err=0.
//   Reset mid-sequence aborts immediately. No partial codes are issued after it.
//   All outputs are registered Moore outputs of the state. Codes are HOLD unless stated.
//   op/amt are latched into op_q/cnt on the accepting edge and are ignored afterwards.
//   States and transitions:
//     IDLE : start=1 -> latch; op 0-3 -> LDX; 4/5 -> SHIFT; 6 -> CLR; 7 -> DONE(err)
//     LDX  : Tx=LOAD                              -> EXEC
//     EXEC : Ty=LOAD, alu_sel=op_q[1:0]           -> WRZ
//     WRZ  : Tz=LOAD                              -> DONE
//     SHIFT: Tz=SHIFTR (op 4) or SHIFTL (op 5); cnt==0 -> DONE else cnt<=cnt-1, stay
//     CLR  : Tx=Ty=Tz=CLEAR                       -> DONE
//     DONE : done=1 (err=1 iff op_q==7), busy=1   -> IDLE
//   Latency from the accepting edge E to the done pulse:
//     ALU op: E+4 (LDX@E+1, EXEC@E+2, WRZ@E+3, DONE@E+4)
//     shift: E+amt+2
//     CLR: E+2
//     reserved: E+1
//   start while busy (including in DONE) is ignored and is not queued.
//   start in IDLE on the cycle after DONE is accepted. Back-to-back issue period = latency+1.
//   cnt wraps nowhere: it counts down from amt to 0 and exits at 0; amt=0 gives one shift.
//   start=1 together with rst=1: reset wins and the request is lost.
//   Unused code values 5..(2^CODE_W-1) are never driven.
// TESTING
//   1. rst held 2 cycles mid-EXEC -> next cycle IDLE, Tx=Ty=Tz=0, busy=0, done=0.
//   2. start, op=1 (SUB) -> Tx=1 @E+1, Ty=1 with alu_sel=01 @E+2, Tz=1 @E+3, done @E+4.
//   3. start, op=4, amt=2 -> Tz=2 for exactly 3 cycles, done @E+4, err=0.
//   4. start, op=6 -> Tx=Ty=Tz=4 for 1 cycle, done @E+2; op=7 -> done=err=1 @E+1, codes HOLD.
//   5. start pulsed at E+1..E+4 during ADD -> ignored; start @E+5 accepted (LDX @E+6).
//   6. With X=0011 and Y datapath: ADD then op=5, amt=0 -> registerZ ends at (X+Y)<<1, 4-bit truncated.

Source files
------------

// File: rtl/calc_control.sv
// Operation sequencer driving registerX/Y/Z op codes and the ALU select.
// All outputs are registered from the next state so they change only on posedge clk.
module calc_control #(
   parameter int CODE_W = 4,
   parameter int AMT_W  = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [2:0]        op,
   input  logic [AMT_W-1:0]  amt,
   output logic [CODE_W-1:0] Tx,
   output logic [CODE_W-1:0] Ty,
   output logic [CODE_W-1:0] Tz,
   output logic [1:0]        alu_sel,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam logic [CODE_W-1:0] HOLD   = CODE_W'(0);
   localparam logic [CODE_W-1:0] LOAD   = CODE_W'(1);
   localparam logic [CODE_W-1:0] SHIFTR = CODE_W'(2);
   localparam logic [CODE_W-1:0] SHIFTL = CODE_W'(3);
   localparam logic [CODE_W-1:0] CLEAR  = CODE_W'(4);

   typedef enum logic [2:0] {
      IDLE, LDX, EXEC, WRZ, SHIFT, CLR, DONE
   } state_t;

   state_t           state, state_n;
   logic [2:0]       op_q, op_n;
   logic [AMT_W-1:0] cnt, cnt_n;

   always_comb begin
      state_n = state;
      op_n    = op_q;
      cnt_n   = cnt;
      case (state)
         IDLE: if (start) begin
            op_n  = op;
            cnt_n = amt;
            case (op)
               3'd0, 3'd1, 3'd2, 3'd3: state_n = LDX;
               3'd4, 3'd5:             state_n = SHIFT;
               3'd6:                   state_n = CLR;
               default:                state_n = DONE;
            endcase
         end
         LDX:   state_n = EXEC;
         EXEC:  state_n = WRZ;
         WRZ:   state_n = DONE;
         SHIFT: if (cnt == '0) state_n = DONE;
                else cnt_n = cnt - AMT_W'(1);
         CLR:   state_n = DONE;
         DONE:  state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // Outputs are decoded from state_n/op_n so they line up with the state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         op_q    <= '0;
         cnt     <= '0;
         Tx      <= HOLD;
         Ty      <= HOLD;
         Tz      <= HOLD;
         alu_sel <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         err     <= 1'b0;
      end else begin
         state   <= state_n;
         op_q    <= op_n;
         cnt     <= cnt_n;
         Tx      <= HOLD;
         Ty      <= HOLD;
         Tz      <= HOLD;
         alu_sel <= '0;
         busy    <= (state_n != IDLE);
         done    <= (state_n == DONE);
         err     <= (state_n == DONE) && (op_n == 3'd7);
         case (state_n)
            LDX:   Tx <= LOAD;
            EXEC: begin
               Ty      <= LOAD;
               alu_sel <= op_n[1:0];
            end
            WRZ:   Tz <= LOAD;
            SHIFT: Tz <= op_n[0] ? SHIFTL : SHIFTR;
            CLR: begin
               Tx <= CLEAR;
               Ty <= CLEAR;
               Tz <= CLEAR;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_calc_control.sv
// Bench for calc_control: per-cycle output scoreboard plus a small register/ALU datapath.
module tb_calc_control;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start = 1'b0;
   logic [2:0] op = '0;
   logic [1:0] amt = '0;
   logic [3:0] Tx, Ty, Tz;
   logic [1:0] alu_sel;
   logic       busy, done, err;

   int unsigned assertions = 0;
   int unsigned failures   = 0;
   logic        armed = 1'b0;
   string       cur = "init";

   // {Tx,Ty,Tz,alu_sel,busy,done,err}
   logic [16:0] sb[$];
   localparam logic [16:0] IDLE_E = '0;

   logic [3:0] x, y, z;
   logic       dp_init = 1'b0;

   calc_control #(.CODE_W(4), .AMT_W(2)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .amt(amt),
      .Tx(Tx), .Ty(Ty), .Tz(Tz), .alu_sel(alu_sel),
      .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   function automatic logic [16:0] mk(input logic [3:0] tx, input logic [3:0] ty,
                                       input logic [3:0] tz, input logic [1:0] sel,
                                       input logic b, input logic d, input logic e);
      return {tx, ty, tz, sel, b, d, e};
   endfunction

   // Expected outputs for the cycles following an accepted request.
   function automatic void push_seq(input logic [2:0] o, input logic [1:0] a);
      case (o)
         3'd0, 3'd1, 3'd2, 3'd3: begin
            sb.push_back(mk(4'd1, 4'd0, 4'd0, 2'd0, 1'b1, 1'b0, 1'b0));
            sb.push_back(mk(4'd0, 4'd1, 4'd0, o[1:0], 1'b1, 1'b0, 1'b0));
            sb.push_back(mk(4'd0, 4'd0, 4'd1, 2'd0, 1'b1, 1'b0, 1'b0));
         end
         3'd4, 3'd5: begin
            for (int i = 0; i <= int'(a); i++)
               sb.push_back(mk(4'd0, 4'd0, (o == 3'd4) ? 4'd2 : 4'd3, 2'd0, 1'b1, 1'b0, 1'b0));
         end
         3'd6: sb.push_back(mk(4'd4, 4'd4, 4'd4, 2'd0, 1'b1, 1'b0, 1'b0));
         default: ;
      endcase
      sb.push_back(mk(4'd0, 4'd0, 4'd0, 2'd0, 1'b1, 1'b1, (o == 3'd7)));
   endfunction

   // Scoreboard: every cycle's outputs are compared; an empty queue means IDLE is expected.
   always @(posedge clk) begin
      logic [16:0] exp_v, got;
      #1;
      if (armed) begin
         exp_v = (sb.size() != 0) ? sb.pop_front() : IDLE_E;
         got   = {Tx, Ty, Tz, alu_sel, busy, done, err};
         assertions++;
         if (got !== exp_v) begin
            failures++;
            $display("FAIL %s outputs got %h expected %h at %0t", cur, got, exp_v, $time);
         end
      end
   end

   // Behavioural registerX/Y/Z and ALU sampling the codes on negedge.
   always @(negedge clk) begin
      if (dp_init) begin
         x <= 4'd0;
         y <= 4'd11;
         z <= 4'd0;
      end else begin
         if (Tx == 4'd1) x <= 4'd3;
         else if (Tx == 4'd4) x <= 4'd0;
         if (Ty == 4'd1) begin
            case (alu_sel)
               2'd0: y <= x + y;
               2'd1: y <= x - y;
               2'd2: y <= x & y;
               default: y <= x | y;
            endcase
         end else if (Ty == 4'd4) y <= 4'd0;
         case (Tz)
            4'd1: z <= y;
            4'd2: z <= z >> 1;
            4'd3: z <= z << 1;
            4'd4: z <= 4'd0;
            default: ;
         endcase
      end
   end

   task automatic issue(input logic [2:0] o, input logic [1:0] a);
      start = 1'b1;
      op    = o;
      amt   = a;
      push_seq(o, a);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_cycles(input int unsigned n);
      repeat (n) @(negedge clk);
   endtask

   task automatic test_reset();
      cur   = "reset";
      rst   = 1'b1;
      start = 1'b1;
      op    = 3'd0;
      armed = 1'b1;
      @(negedge clk);
      rst   = 1'b0;
      start = 1'b0;
      wait_cycles(2);
      assertions++;
      if (busy !== 1'b0 || done !== 1'b0 || Tx !== 4'd0) begin
         failures++;
         $display("FAIL reset_state got busy=%b done=%b Tx=%h expected 0 0 0", busy, done, Tx);
      end
   endtask

   task automatic test_abort();
      cur = "abort";
      issue(3'd0, 2'd0);
      @(negedge clk);
      rst = 1'b1;
      sb.delete();
      wait_cycles(2);
      rst = 1'b0;
      wait_cycles(2);
      assertions++;
      if ({Tx, Ty, Tz, busy, done} !== 14'd0) begin
         failures++;
         $display("FAIL abort_idle got %h expected 0", {Tx, Ty, Tz, busy, done});
      end
   endtask

   task automatic test_alu();
      cur = "alu";
      for (int unsigned i = 0; i < 4; i++) begin
         issue(3'(i), 2'd3);
         op = 3'd7;
         wait_cycles(5);
      end
      assertions++;
      if (sb.size() != 0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL alu_drain got pending=%0d busy=%b expected 0 0", sb.size(), busy);
      end
   endtask

   task automatic test_shift();
      cur = "shift";
      issue(3'd4, 2'd2);
      wait_cycles(5);
      issue(3'd5, 2'd3);
      wait_cycles(6);
      issue(3'd4, 2'd0);
      wait_cycles(3);
      assertions++;
      if (err !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL shift_end got err=%b busy=%b expected 0 0", err, busy);
      end
   endtask

   task automatic test_clr_reserved();
      cur = "clr_reserved";
      issue(3'd6, 2'd0);
      wait_cycles(3);
      issue(3'd7, 2'd0);
      assertions++;
      if (done !== 1'b1 || err !== 1'b1 || Tz !== 4'd0) begin
         failures++;
         $display("FAIL reserved_done got done=%b err=%b Tz=%h expected 1 1 0", done, err, Tz);
      end
      wait_cycles(2);
   endtask

   task automatic test_back_to_back();
      cur = "back_to_back";
      start = 1'b1;
      op    = 3'd0;
      amt   = 2'd0;
      push_seq(3'd0, 2'd0);
      for (int unsigned k = 0; k < 4; k++) begin
         @(negedge clk);
         op  = 3'd6;
         amt = 2'd3;
      end
      @(negedge clk);
      op = 3'd3;
      push_seq(3'd3, 2'd0);
      @(negedge clk);
      start = 1'b0;
      assertions++;
      if (Tx !== 4'd1 || busy !== 1'b1) begin
         failures++;
         $display("FAIL second_accept got Tx=%h busy=%b expected 1 1", Tx, busy);
      end
      wait_cycles(5);
   endtask

   task automatic test_datapath();
      cur = "datapath";
      @(posedge clk);
      #1 dp_init = 1'b1;
      @(posedge clk);
      #1 dp_init = 1'b0;
      @(negedge clk);
      issue(3'd0, 2'd0);
      wait_cycles(5);
      issue(3'd5, 2'd0);
      wait_cycles(3);
      assertions++;
      if (z !== 4'b1100) begin
         failures++;
         $display("FAIL datapath_z got %h expected %h", z, 4'b1100);
      end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_abort();
      test_alu();
      test_shift();
      test_clr_reserved();
      test_back_to_back();
      test_datapath();
      $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
      $finish;
   end

endmodule
